// File: rtl/snp_bram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : snp_bram_loader                                                   |
// | Packs a 64-bit id/plane word stream into SNP genotype BRAM rows and kicks   |
// | the PE array once the buffer is full. Option macro: SNP_LOADER_IDCHECK_EN.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module snp_bram_loader #(
  parameter int DATA_WIDTH  = 64,
  parameter int PE_WIDTH    = 16,
  parameter int BLOCK_WIDTH = 16,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PE_WIDTH-1:0]     SNP_num_in,
  input  logic [BLOCK_WIDTH-1:0]  SNP_length_in,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    bram_wr_en,
  output logic [ADDR_WIDTH-1:0]   bram_wr_addr,
  output logic [4*DATA_WIDTH-1:0] bram_wr_data,
  output logic                    array_start,
  output logic                    busy,
  output logic                    done,
  output logic                    id_err
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LOAD  = 3'd1;
  localparam logic [2:0] c_FLUSH = 3'd2;
  localparam logic [2:0] c_START = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [PE_WIDTH-1:0]    c_PE_ONE   = PE_WIDTH'(1);
  localparam logic [BLOCK_WIDTH-1:0] c_BLK_ONE  = BLOCK_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  c_ADDR_ONE = ADDR_WIDTH'(1);

  logic [2:0]             r_state;
  logic [PE_WIDTH-1:0]    r_num;
  logic [BLOCK_WIDTH-1:0] r_len;
  logic [1:0]             r_word_idx;
  logic [BLOCK_WIDTH-1:0] r_block_pos;
  logic [PE_WIDTH-1:0]    r_snp_pos;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [PE_WIDTH-1:0]    r_id;
  logic [DATA_WIDTH-1:0]  r_plane0;
  logic [DATA_WIDTH-1:0]  r_plane1;

  logic                   w_accept;
  logic                   w_row_done;
  logic                   w_last_block;
  logic                   w_last_snp;
  logic [DATA_WIDTH-1:0]  w_id_field;

  assign s_ready      = (r_state == c_LOAD);
  assign busy         = (r_state == c_LOAD) || (r_state == c_FLUSH);
  assign array_start  = (r_state == c_START);
  assign done         = (r_state == c_DONE);
  assign w_accept     = s_valid && s_ready;
  assign w_row_done   = w_accept && (r_word_idx == 2'd3);
  assign w_last_block = (r_block_pos == r_len - c_BLK_ONE);
  assign w_last_snp   = (r_snp_pos == r_num - c_PE_ONE);
  assign w_id_field   = DATA_WIDTH'(r_id);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_num        <= '0;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_block_pos  <= '0;
      r_snp_pos    <= '0;
      r_addr       <= '0;
      r_id         <= '0;
      r_plane0     <= '0;
      r_plane1     <= '0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
    end else begin
      bram_wr_en <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_num       <= SNP_num_in;
            r_len       <= SNP_length_in;
            r_word_idx  <= '0;
            r_block_pos <= '0;
            r_snp_pos   <= '0;
            r_addr      <= '0;
            r_state     <= ((SNP_num_in == '0) || (SNP_length_in == '0)) ? c_DONE : c_LOAD;
          end
        end
        c_LOAD: begin
          if (w_accept) begin
            r_word_idx <= r_word_idx + 2'd1;
            case (r_word_idx)
              2'd0:    r_id     <= s_data[PE_WIDTH-1:0];
              2'd1:    r_plane0 <= s_data;
              2'd2:    r_plane1 <= s_data;
              default: begin
                // Fourth word goes straight into the row so the write lands one cycle later.
                bram_wr_en   <= 1'b1;
                bram_wr_addr <= r_addr;
                bram_wr_data <= {w_id_field, s_data, r_plane1, r_plane0};
                r_addr       <= r_addr + c_ADDR_ONE;
                if (w_last_block) begin
                  r_block_pos <= '0;
                  r_snp_pos   <= r_snp_pos + c_PE_ONE;
                  if (w_last_snp) r_state <= c_FLUSH;
                end else begin
                  r_block_pos <= r_block_pos + c_BLK_ONE;
                end
              end
            endcase
          end
        end
        c_FLUSH: r_state <= c_START;
        c_START: r_state <= c_DONE;
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef SNP_LOADER_IDCHECK_EN
  logic [PE_WIDTH-1:0] r_prev_id;
  logic                w_id_bad;

  // Within an SNP the id repeats; the first block of the next SNP must step it by one.
  always_comb begin
    w_id_bad = 1'b0;
    if (r_block_pos != '0)
      w_id_bad = (r_id != r_prev_id);
    else if (r_snp_pos != '0)
      w_id_bad = (r_id != r_prev_id + c_PE_ONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_id <= '0;
      id_err    <= 1'b0;
    end else if ((r_state == c_IDLE) && start) begin
      id_err <= 1'b0;
    end else if (w_row_done) begin
      r_prev_id <= r_id;
      if (w_id_bad) id_err <= 1'b1;
    end
  end
`else
  assign id_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snp_bram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_snp_bram_loader                                                |
// | Directed and randomized loads of snp_bram_loader against a row-level model. |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_snp_bram_loader;

  localparam int DW = 64;
  localparam int PW = 16;
  localparam int BW = 16;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PW-1:0]   SNP_num_in;
  logic [BW-1:0]   SNP_length_in;
  logic            s_valid;
  logic [DW-1:0]   s_data;
  logic            s_ready;
  logic            bram_wr_en;
  logic [AW-1:0]   bram_wr_addr;
  logic [4*DW-1:0] bram_wr_data;
  logic            array_start;
  logic            busy;
  logic            done;
  logic            id_err;

  snp_bram_loader #(
    .DATA_WIDTH (DW),
    .PE_WIDTH   (PW),
    .BLOCK_WIDTH(BW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .SNP_num_in   (SNP_num_in),
    .SNP_length_in(SNP_length_in),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .array_start  (array_start),
    .busy         (busy),
    .done         (done),
    .id_err       (id_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0]   wr_addr_q[$];
  logic [4*DW-1:0] wr_data_q[$];
  int              wr_cyc_q[$];
  int              as_q[$];
  int              done_q[$];
  int              hs_q[$];
  int              sready_cnt = 0;
  logic [DW-1:0]   feed_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (bram_wr_en) begin
      wr_addr_q.push_back(bram_wr_addr);
      wr_data_q.push_back(bram_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (array_start) as_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (s_ready) sready_cnt++;
  end

  task automatic chk(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    as_q.delete();
    done_q.delete();
    hs_q.delete();
    sready_cnt = 0;
  endtask

  // Offers feed_q words in order; vmode 0 = always valid, 1 = toggling, 2 = random.
  task automatic feed(input int limit, input int vmode);
    int idx = 0;
    int guard = 0;
    while (idx < limit && guard < 4000) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = (guard % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = s_valid ? feed_q[idx] : {$urandom, $urandom};
      @(negedge clk);
      if (s_valid && s_ready) begin
        if (idx % 4 == 3) hs_q.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    chk("feed_complete", idx, limit);
  endtask

  task automatic issue_start(input int num, input int len);
    @(posedge clk); #1;
    clear_mon();
    start         = 1'b1;
    SNP_num_in    = PW'(num);
    SNP_length_in = BW'(len);
    @(posedge clk); #1;
    start         = 1'b0;
    SNP_num_in    = PW'($urandom);
    SNP_length_in = BW'($urandom);
  endtask

  task automatic run_load(input int num, input int len, input int vmode,
                          input bit skip_ids, input logic [PW-1:0] base);
    int              rows = num * len;
    logic [PW-1:0]   ids[$];
    logic [4*DW-1:0] exp_rows[$];
    bit              exp_err = 1'b0;
    logic [DW-1:0]   p0, p1, p2;
    logic            exp_id_err;
    feed_q.delete();
    for (int r = 0; r < rows; r++) begin
      ids.push_back(skip_ids ? PW'(base + 2 * (r / len)) : PW'(base + r / len));
      p0 = {$urandom, $urandom};
      p1 = {$urandom, $urandom};
      p2 = {$urandom, $urandom};
      feed_q.push_back({$urandom, 16'($urandom), ids[r]});
      feed_q.push_back(p0);
      feed_q.push_back(p1);
      feed_q.push_back(p2);
      exp_rows.push_back({48'h0, ids[r], p2, p1, p0});
      if (r > 0 && (r % len) != 0 && ids[r] != ids[r-1]) exp_err = 1'b1;
      if (r > 0 && (r % len) == 0 && ids[r] != PW'(ids[r-1] + 16'd1)) exp_err = 1'b1;
    end
`ifdef SNP_LOADER_IDCHECK_EN
    exp_id_err = exp_err;
`else
    exp_id_err = 1'b0;
`endif
    issue_start(num, len);
    if (rows > 0) feed(rows * 4, vmode);
    for (int i = 0; i < 50 && done_q.size() == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("wr_count", wr_addr_q.size(), rows);
    for (int i = 0; i < wr_addr_q.size() && i < rows; i++) begin
      chk($sformatf("wr_addr[%0d]", i), wr_addr_q[i], i);
      chk($sformatf("wr_data[%0d]", i), wr_data_q[i], exp_rows[i]);
      if (i < hs_q.size()) chk($sformatf("wr_latency[%0d]", i), wr_cyc_q[i], hs_q[i] + 1);
    end
    chk("array_start_pulses", as_q.size(), (rows > 0) ? 1 : 0);
    chk("done_pulses", done_q.size(), 1);
    if (as_q.size() == 1 && wr_cyc_q.size() > 0)
      chk("array_start_timing", as_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
    if (as_q.size() == 1 && done_q.size() == 1)
      chk("done_timing", done_q[0], as_q[0] + 1);
    if (rows == 0) chk("s_ready_never", sready_cnt, 0);
    if (rows > 0) chk("addr_hold", bram_wr_addr, rows - 1);
    chk("id_err", id_err, exp_id_err);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    SNP_num_in = '0;
    SNP_length_in = '0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {s_ready, bram_wr_en, array_start, busy, done, id_err}, 6'b0);
    chk("reset_addr", bram_wr_addr, 0);
    chk("reset_data", bram_wr_data, 0);
    rst = 1'b0;

    run_load(2, 3, 0, 1'b0, PW'($urandom));   // continuous, 6 rows
    run_load(1, 1, 0, 1'b0, 16'd7);           // single row packing
    run_load(1, 2, 1, 1'b0, PW'($urandom));   // toggling valid
    run_load(0, 3, 0, 1'b0, 16'd0);           // empty: no SNPs
    run_load(2, 0, 0, 1'b0, 16'd0);           // empty: no blocks

    // Reset in the middle of the second row.
    feed_q.delete();
    for (int i = 0; i < 8; i++) feed_q.push_back({$urandom, $urandom});
    issue_start(2, 2);
    feed(6, 0);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {s_ready, bram_wr_en, array_start, busy, done}, 5'b0);
    chk("midrst_addr", bram_wr_addr, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_writes", wr_addr_q.size(), 1);
    chk("midrst_no_start", as_q.size(), 0);
    run_load(2, 2, 0, 1'b0, PW'($urandom));   // reload from address 0

    run_load(2, 2, 0, 1'b1, 16'd3);           // ids 3,3,5,5
    run_load(2, 2, 0, 1'b0, 16'd9);           // error cleared by new start

    for (int k = 0; k < 6; k++)
      run_load($urandom_range(1, 3), $urandom_range(1, 4), 2,
               1'($urandom_range(0, 1)), PW'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
